// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter and fixed-latency sequencer for the data memory.
// Optional grant statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1,
`endif
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [3:0]        cnt_q, cnt_d;

  logic busy, fin, own, pick;

  // Arbitration, command latch and access sequencing.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    // On a tie the requester that did not own the memory last wins.
    pick    = (m0_req && m1_req) ? ~last_q : m1_req;
    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          owner_d = pick;
          we_d    = pick ? m1_we    : m0_we;
          addr_d  = pick ? m1_addr  : m0_addr;
          wdata_d = pick ? m1_wdata : m0_wdata;
          cnt_d   = CNT_INIT;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and command registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode from state so reset clears them without waiting for a clock.
  always_comb begin
    busy      = (state_q == S_BUSY);
    fin       = (state_q == S_DONE);
    own       = busy | fin;
    m0_gnt    = own & ~owner_q;
    m1_gnt    = own & owner_q;
    m0_done   = fin & ~owner_q;
    m1_done   = fin & owner_q;
    // Counter still at its load value marks the first busy cycle.
    mem_we    = busy & we_q & (cnt_q == CNT_INIT);
    mem_re    = busy & ~we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    rdata     = rdata_q;
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [15:0] gnt_cnt1_q, gnt_cnt1_d;

  // Saturating per-requester completion counters.
  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (m0_done && gnt_cnt0_q != 16'hFFFF) gnt_cnt0_d = gnt_cnt0_q + 16'd1;
    if (m1_done && gnt_cnt1_q != 16'hFFFF) gnt_cnt1_d = gnt_cnt1_q + 16'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0_q <= 16'd0;
      gnt_cnt1_q <= 16'd0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one-cycle and three-cycle instances,
// completions checked against a queue of expected owner/read data.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        owner;
    logic [31:0] rd;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  sb_t sb_q[$];
  logic [31:0] exp_rd;

  // instance A: WAIT_CYCLES = 1
  logic        a_m0_req, a_m0_we, a_m0_gnt, a_m0_done;
  logic [10:0] a_m0_addr;
  logic [31:0] a_m0_wdata;
  logic        a_m1_req, a_m1_we, a_m1_gnt, a_m1_done;
  logic [10:0] a_m1_addr;
  logic [31:0] a_m1_wdata;
  logic [31:0] a_rdata, a_mem_wdata, a_mem_rdata, a_rd;
  logic [10:0] a_mem_addr;
  logic        a_mem_we, a_mem_re;
  assign a_mem_rdata = a_rd ^ {21'd0, a_mem_addr};

  // instance B: WAIT_CYCLES = 3
  logic        b_m0_req, b_m0_we, b_m0_gnt, b_m0_done;
  logic [10:0] b_m0_addr;
  logic [31:0] b_m0_wdata;
  logic        b_m1_req, b_m1_we, b_m1_gnt, b_m1_done;
  logic [10:0] b_m1_addr;
  logic [31:0] b_m1_wdata;
  logic [31:0] b_rdata, b_mem_wdata, b_mem_rdata, b_rd;
  logic [10:0] b_mem_addr;
  logic        b_mem_we, b_mem_re;
  assign b_mem_rdata = b_rd ^ {21'd0, b_mem_addr};

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] a_cnt0, a_cnt1, b_cnt0, b_cnt1;
`endif

  dmem_arbiter #(.ADDR_W(11), .DATA_W(32), .WAIT_CYCLES(1)) u_a (
    .clk(clk), .rst(rst),
`ifdef DMEM_ARB_STATS_EN
    .gnt_cnt0(a_cnt0), .gnt_cnt1(a_cnt1),
`endif
    .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr),
    .m0_wdata(a_m0_wdata), .m0_gnt(a_m0_gnt), .m0_done(a_m0_done),
    .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr),
    .m1_wdata(a_m1_wdata), .m1_gnt(a_m1_gnt), .m1_done(a_m1_done),
    .rdata(a_rdata), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_we(a_mem_we), .mem_re(a_mem_re), .mem_rdata(a_mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(11), .DATA_W(32), .WAIT_CYCLES(3)) u_b (
    .clk(clk), .rst(rst),
`ifdef DMEM_ARB_STATS_EN
    .gnt_cnt0(b_cnt0), .gnt_cnt1(b_cnt1),
`endif
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr),
    .m0_wdata(b_m0_wdata), .m0_gnt(b_m0_gnt), .m0_done(b_m0_done),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr),
    .m1_wdata(b_m1_wdata), .m1_gnt(b_m1_gnt), .m1_done(b_m1_done),
    .rdata(b_rdata), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_we(b_mem_we), .mem_re(b_mem_re), .mem_rdata(b_mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a done on instance A, then score it against the queue.
  task automatic wait_done_a(input int max, output int n);
    sb_t e;
    n = 0;
    while (!(a_m0_done || a_m1_done) && n < max) begin
      chk("a_gnt_excl", 32'(a_m0_gnt & a_m1_gnt), 32'd0);
      tick();
      n++;
    end
    if (!(a_m0_done || a_m1_done)) begin
      chk("a_done_timeout", 32'(a_m0_done | a_m1_done), 32'd1);
    end else if (sb_q.size() == 0) begin
      chk("a_sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("a_done_excl", 32'(a_m0_done & a_m1_done), 32'd0);
      chk("a_done_owner", 32'(a_m1_done), 32'(e.owner));
      chk("a_rdata", a_rdata, e.rd);
    end
  endtask

  int n;

  initial begin
    {a_m0_req, a_m0_we, a_m1_req, a_m1_we} = '0;
    {b_m0_req, b_m0_we, b_m1_req, b_m1_we} = '0;
    a_m0_addr = '0; a_m1_addr = '0; a_m0_wdata = '0; a_m1_wdata = '0;
    b_m0_addr = '0; b_m1_addr = '0; b_m0_wdata = '0; b_m1_wdata = '0;
    a_rd = '0; b_rd = '0; exp_rd = '0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_gnt", 32'({a_m0_gnt, a_m1_gnt, b_m0_gnt, b_m1_gnt}), 32'd0);
    chk("rst_done", 32'({a_m0_done, a_m1_done, b_m0_done, b_m1_done}), 32'd0);
    chk("rst_mem_we_re", 32'({a_mem_we, a_mem_re, b_mem_we, b_mem_re}), 32'd0);
    chk("rst_mem_addr", 32'(a_mem_addr), 32'd0);
    chk("rst_mem_wdata", a_mem_wdata, 32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
`ifdef DMEM_ARB_STATS_EN
    chk("rst_cnt", {a_cnt0, a_cnt1}, 32'd0);
`endif

    // m0 read, one wait cycle
    a_rd = 32'hDEADBEEF ^ 32'h010;
    a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 11'h010;
    exp_rd = 32'hDEADBEEF;
    sb_q.push_back('{owner: 1'b0, rd: exp_rd});
    tick();
    chk("t1_m0_gnt", 32'(a_m0_gnt), 32'd1);
    chk("t1_m1_gnt", 32'(a_m1_gnt), 32'd0);
    chk("t1_mem_re", 32'(a_mem_re), 32'd1);
    chk("t1_mem_we", 32'(a_mem_we), 32'd0);
    chk("t1_mem_addr", 32'(a_mem_addr), 32'h010);
    chk("t1_done_early", 32'(a_m0_done), 32'd0);
    a_m0_req = 1'b0;
    wait_done_a(4, n);
    chk("t1_latency", 32'(n), 32'd1);
    chk("t1_re_in_done", 32'(a_mem_re), 32'd0);
    chk("t1_gnt_in_done", 32'(a_m0_gnt), 32'd1);
    tick();
    chk("t1_idle_gnt", 32'({a_m0_gnt, a_m0_done}), 32'd0);

    // m1 write, rdata must hold
    a_m1_req = 1'b1; a_m1_we = 1'b1;
    a_m1_addr = 11'h3FF; a_m1_wdata = 32'h12345678;
    sb_q.push_back('{owner: 1'b1, rd: exp_rd});
    tick();
    chk("t2_m1_gnt", 32'({a_m0_gnt, a_m1_gnt}), 32'd1);
    chk("t2_mem_we", 32'(a_mem_we), 32'd1);
    chk("t2_mem_re", 32'(a_mem_re), 32'd0);
    chk("t2_mem_addr", 32'(a_mem_addr), 32'h3FF);
    chk("t2_mem_wdata", a_mem_wdata, 32'h12345678);
    a_m1_req = 1'b0;
    wait_done_a(4, n);
    chk("t2_latency", 32'(n), 32'd1);
    chk("t2_we_in_done", 32'(a_mem_we), 32'd0);
    tick();
    chk("t2_idle", 32'({a_m1_gnt, a_m1_done, a_mem_we}), 32'd0);

    // three wait cycles; m0 drops req and moves addr after grant
    b_rd = 32'h5A5A0000;
    b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 11'h055;
    tick();
    b_m0_req = 1'b0; b_m0_addr = 11'h066;
    for (int i = 0; i < 3; i++) begin
      chk("t4_gnt", 32'({b_m0_gnt, b_m1_gnt}), 32'd2);
      chk("t4_mem_re", 32'(b_mem_re), 32'd1);
      chk("t4_mem_addr", 32'(b_mem_addr), 32'h055);
      chk("t4_done_early", 32'(b_m0_done), 32'd0);
      tick();
    end
    chk("t4_done", 32'({b_m0_done, b_m1_done}), 32'd2);
    chk("t4_re_off", 32'(b_mem_re), 32'd0);
    chk("t4_rdata", b_rdata, 32'h5A5A0000 ^ 32'h055);
    tick();
    chk("t4_idle", 32'({b_m0_gnt, b_m0_done}), 32'd0);
    tick();
    chk("t4_no_regrant", 32'({b_m0_gnt, b_mem_re}), 32'd0);

    // three wait cycles write: strobe only in the first busy cycle
    b_m1_req = 1'b1; b_m1_we = 1'b1;
    b_m1_addr = 11'h100; b_m1_wdata = 32'hCAFEF00D;
    tick();
    b_m1_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4w_mem_we", 32'(b_mem_we), 32'(i == 0));
      chk("t4w_gnt", 32'({b_m0_gnt, b_m1_gnt}), 32'd1);
      tick();
    end
    chk("t4w_done", 32'({b_m0_done, b_m1_done}), 32'd1);
    chk("t4w_rdata_held", b_rdata, 32'h5A5A0000 ^ 32'h055);
    tick();

    // both requesting from reset: 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_rd = 32'd0;
    chk("t3_rdata_rst", a_rdata, 32'd0);
    a_rd = 32'h0BAD0000;
    a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 11'h020;
    a_m1_req = 1'b1; a_m1_we = 1'b0; a_m1_addr = 11'h030;
    for (int i = 0; i < 4; i++)
      sb_q.push_back('{owner: 1'(i % 2),
                       rd: 32'h0BAD0000 ^ ((i % 2) ? 32'h030 : 32'h020)});
    for (int i = 0; i < 4; i++) begin
      wait_done_a(6, n);
      chk("t3_latency", 32'(n), 32'd2);
      if (i == 3) begin
        a_m0_req = 1'b0;
        a_m1_req = 1'b0;
      end
      tick();
    end
    exp_rd = 32'h0BAD0000 ^ 32'h030;
`ifdef DMEM_ARB_STATS_EN
    chk("t3_cnt0", 32'(a_cnt0), 32'd2);
    chk("t3_cnt1", 32'(a_cnt1), 32'd2);
`endif

    // m0 alone so m1 wins the next tie, then reset mid-busy
    a_m0_req = 1'b1; a_m0_addr = 11'h040;
    exp_rd = 32'h0BAD0000 ^ 32'h040;
    sb_q.push_back('{owner: 1'b0, rd: exp_rd});
    wait_done_a(6, n);
    chk("t5_pre_latency", 32'(n), 32'd2);
    a_m0_req = 1'b0;
    tick();
    a_m0_req = 1'b1; a_m1_req = 1'b1;
    tick();
    chk("t5_m1_won", 32'({a_m0_gnt, a_m1_gnt}), 32'd1);
    chk("t5_re_busy", 32'(a_mem_re), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_gnt", 32'({a_m0_gnt, a_m1_gnt}), 32'd0);
    chk("t5_rst_re", 32'(a_mem_re), 32'd0);
    chk("t5_rst_done", 32'({a_m0_done, a_m1_done}), 32'd0);
    chk("t5_rst_rdata", a_rdata, 32'd0);
    tick();
    chk("t5_hold_done", 32'({a_m0_done, a_m1_done}), 32'd0);
    rst = 1'b0;
    exp_rd = 32'h0BAD0000 ^ 32'h040;
    sb_q.push_back('{owner: 1'b0, rd: exp_rd});
    tick();
    chk("t5_first_gnt", 32'({a_m0_gnt, a_m1_gnt}), 32'd2);
    a_m0_req = 1'b0; a_m1_req = 1'b0;
    wait_done_a(4, n);
    chk("t5_latency", 32'(n), 32'd1);
    tick();

`ifdef DMEM_ARB_STATS_EN
    // saturation: preload near the top and keep completing m0 reads
    chk("t6_cnt0_start", 32'(a_cnt0), 32'd1);
    u_a.gnt_cnt0_q = 16'hFFFD;
    a_m0_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{owner: 1'b0, rd: exp_rd});
      wait_done_a(6, n);
      if (i == 2) a_m0_req = 1'b0;
      tick();
      chk("t6_cnt0", 32'(a_cnt0), (i == 0) ? 32'hFFFE : 32'hFFFF);
    end
    chk("t6_cnt1", 32'(a_cnt1), 32'd0);
`endif

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory behind the memory decoder.
- Requester 0 is the CPU load/store path; requester 1 is a debug/DMA port.
- Grants one requester at a time with round-robin fairness, latches its command, and sequences a fixed-latency memory access.
- Returns read data with a one-cycle done pulse to the owner.

Parameters:
- ADDR_W, 11, physical data-memory address width.
- DATA_W, 32, data width.
- WAIT_CYCLES, 1, memory access cycles per transaction; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- m0_req  in  1  requester 0 access request, level
- m0_we  in  1  requester 0 write (1) / read (0)
- m0_addr  in  ADDR_W  requester 0 physical address
- m0_wdata  in  DATA_W  requester 0 write data
- m0_gnt  out  1  requester 0 owns the memory
- m0_done  out  1  requester 0 transaction complete, one-cycle pulse
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done: same as requester 0, for requester 1
- rdata  out  DATA_W  read data of the last completed read, shared by both requesters
- mem_addr  out  ADDR_W  to data memory
- mem_wdata  out  DATA_W  to data memory
- mem_we  out  1  to data memory, write strobe
- mem_re  out  1  to data memory, read enable
- mem_rdata  in  DATA_W  from data memory, combinational read

Behaviour:
- Reset is applied immediately, not on a clock edge. It sets state=IDLE; gnt, done, mem_we, mem_re = 0; mem_addr, mem_wdata, rdata = 0; last_owner = 1, so requester 0 wins the first tie; wait counter = 0.
- State IDLE:
  - No request: stay in IDLE.
  - Exactly one req: grant it.
  - Both req: grant the requester that is not last_owner.
  - On the granting edge: latch owner, we, addr, wdata; load counter = WAIT_CYCLES-1; go to BUSY.
- State BUSY:
  - Owner gnt = 1.
  - mem_addr and mem_wdata come from the latched registers.
  - Write: mem_we = 1 in the first BUSY cycle only.
  - Read: mem_re = 1 in every BUSY cycle.
  - Counter decrements each cycle. At counter = 0, the next edge captures mem_rdata into rdata (reads only) and moves to DONE.
- State DONE:
  - Owner gnt = 1, owner done = 1 for exactly one cycle.
  - rdata is valid now and holds until the next read completes. Writes leave rdata unchanged.
  - mem_we = mem_re = 0.
  - last_owner is set to owner; next state is IDLE.
- Latency: a req sampled at edge E gives gnt from E, done in the cycle after E+WAIT_CYCLES, and a return to IDLE at E+WAIT_CYCLES+1. Throughput is WAIT_CYCLES+2 cycles per transaction.
- Request handling:
  - Requests are levels. Deasserting req or changing addr/wdata while granted has no effect; the latched transaction completes.
  - A req still high in IDLE after done starts a new arbitration. Round-robin then grants the other requester if it is waiting.
- The non-owner's gnt and done stay 0 throughout.
- The two gnt outputs are never both 1. The two done outputs are never both 1.
- Async reset during BUSY or DONE aborts the transaction: no done pulse, and mem_we drops at once. A write already strobed is not rolled back.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- When defined:
  - Adds outputs gnt_cnt0 and gnt_cnt1, 16 bits each.
  - Each counts the done pulses of its requester and saturates at 16'hFFFF.
  - Both are cleared by rst.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then m0 read of addr 0x010 with WAIT_CYCLES=1 and mem_rdata=0xDEADBEEF -> m0_gnt from the first edge, mem_re high 1 cycle, m0_done high 1 cycle later, rdata=0xDEADBEEF, back to IDLE after 3 cycles total.
- m1 write addr 0x3FF, wdata 0x12345678 -> mem_we high exactly 1 cycle with mem_addr=0x3FF and mem_wdata=0x12345678; m1_done pulses; rdata unchanged.
- m0 and m1 both requesting continuously from reset -> grants alternate 0,1,0,1; never both gnt; gnt_cnt0=gnt_cnt1=2 after 4 transactions (with STATS).
- WAIT_CYCLES=3; m0 drops req and changes addr one cycle after grant -> mem_re high 3 cycles on the original addr; done after 4 cycles.
- Assert rst mid-BUSY of a read -> gnt, mem_re and done go 0 immediately with no done pulse; the first grant after reset goes to m0.
- STATS: force 65536 m0 transactions -> gnt_cnt0 holds 0xFFFF.
